// File: rtl/tp_pkg.sv
// tp_pkg: shared types, defaults and addressing helper for the ping-pong transpose buffer.
package tp_pkg;

    typedef enum logic {TP_EMPTY, TP_FULL} tp_bank_st_t;

    localparam int TP_N_DEFAULT  = 8;
    localparam int TP_BW_DEFAULT = 8;

    // Flat row-major address of [row][col] in an N x N array with N = 2**lgn.
    function automatic int tp_idx(input int row, input int col, input int lgn);
        return (row << lgn) | col;
    endfunction

endpackage

// File: rtl/tp_bank.sv
// tp_bank: one N x N register array of BW-bit elements with a synchronous write
// port and an asynchronous read port.
module tp_bank
    import tp_pkg::*;
#(
    parameter int BW = TP_BW_DEFAULT,
    parameter int N  = TP_N_DEFAULT
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [$clog2(N)-1:0] wrow,
    input  logic [$clog2(N)-1:0] wcol,
    input  logic [BW-1:0]        wdata,
    input  logic [$clog2(N)-1:0] rrow,
    input  logic [$clog2(N)-1:0] rcol,
    output logic [BW-1:0]        rdata
);
    localparam int LGN = $clog2(N);
    localparam int AW  = 2 * LGN;

    logic [BW-1:0] mem [N*N];
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    assign waddr = AW'(tp_idx(int'(wrow), int'(wcol), LGN));
    assign raddr = AW'(tp_idx(int'(rrow), int'(rcol), LGN));

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tp_buf_pp.sv
// tp_buf_pp: ping-pong N x N transpose buffer, row-major in, column-major out.
// Build option TP_BUF_PASS_EN adds input tp_mode (0 = drain row-major, 1 = transpose).
module tp_buf_pp
    import tp_pkg::*;
#(
    parameter int BW = TP_BW_DEFAULT,
    parameter int N  = TP_N_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [BW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
`ifdef TP_BUF_PASS_EN
    ,
    input  logic          tp_mode
`endif
);
    localparam int             LGN  = $clog2(N);
    localparam logic [LGN-1:0] LAST = LGN'(N - 1);
    localparam logic [LGN-1:0] ONE  = LGN'(1);

    tp_bank_st_t    bank_st [2];
    logic           wsel;
    logic           rsel;
    logic [LGN-1:0] wrow;
    logic [LGN-1:0] wcol;
    logic [LGN-1:0] rd_fast;
    logic [LGN-1:0] rd_slow;
    logic [LGN-1:0] rrow;
    logic [LGN-1:0] rcol;
    logic           rd_tp;
    logic           wr_fire;
    logic           rd_fire;
    logic           wr_end;
    logic           rd_end;
    logic [BW-1:0]  rdata [2];

    assign in_ready  = !rst && (bank_st[wsel] == TP_EMPTY);
    assign out_valid = (bank_st[rsel] == TP_FULL);
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign wr_end    = wr_fire && (wrow == LAST) && (wcol == LAST);
    assign rd_end    = rd_fire && (rd_fast == LAST) && (rd_slow == LAST);

    // Read walk is kept as fast/slow counters; the mode decides which one is the row.
    assign rrow     = rd_tp ? rd_fast : rd_slow;
    assign rcol     = rd_tp ? rd_slow : rd_fast;
    assign out_last = out_valid && (rrow == LAST) && (rcol == LAST);
    assign out_data = out_valid ? rdata[rsel] : '0;

`ifdef TP_BUF_PASS_EN
    logic bank_tp [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_tp[0] <= 1'b1;
            bank_tp[1] <= 1'b1;
        end else if (wr_end) begin
            bank_tp[wsel] <= tp_mode;
        end
    end

    assign rd_tp = bank_tp[rsel];
`else
    assign rd_tp = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st[0] <= TP_EMPTY;
            bank_st[1] <= TP_EMPTY;
            wsel       <= 1'b0;
            rsel       <= 1'b0;
            wrow       <= '0;
            wcol       <= '0;
            rd_fast    <= '0;
            rd_slow    <= '0;
        end else begin
            // Counters wrap to zero on their own since N is a power of two.
            if (wr_fire) begin
                wcol <= wcol + ONE;
                if (wcol == LAST) begin
                    wrow <= wrow + ONE;
                end
                if (wr_end) begin
                    bank_st[wsel] <= TP_FULL;
                    wsel          <= !wsel;
                end
            end
            if (rd_fire) begin
                rd_fast <= rd_fast + ONE;
                if (rd_fast == LAST) begin
                    rd_slow <= rd_slow + ONE;
                end
                if (rd_end) begin
                    bank_st[rsel] <= TP_EMPTY;
                    rsel          <= !rsel;
                end
            end
        end
    end

    tp_bank #(.BW(BW), .N(N)) u_bank0 (
        .clk   (clk),
        .we    (wr_fire && !wsel),
        .wrow  (wrow),
        .wcol  (wcol),
        .wdata (in_data),
        .rrow  (rrow),
        .rcol  (rcol),
        .rdata (rdata[0])
    );

    tp_bank #(.BW(BW), .N(N)) u_bank1 (
        .clk   (clk),
        .we    (wr_fire && wsel),
        .wrow  (wrow),
        .wcol  (wcol),
        .wdata (in_data),
        .rrow  (rrow),
        .rcol  (rcol),
        .rdata (rdata[1])
    );

endmodule

// File: tb/tb_tp_buf_pp.sv
// tb_tp_buf_pp: scoreboard bench for tp_buf_pp; a block-level reference model builds
// the expected output stream from each completed input block.
module tb_tp_buf_pp;
    localparam int BW = 8;
    localparam int N  = 8;
    localparam int NN = N * N;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic [BW-1:0] in_data   = '0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [BW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
`ifdef TP_BUF_PASS_EN
    logic          tp_mode   = 1'b1;
`endif

    typedef struct {
        logic [BW-1:0] d;
        bit            last;
    } exp_t;

    exp_t          exp_q [$];
    logic [BW-1:0] blk [$];
    int            pend     = 0;
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;

    always #5 clk = ~clk;

    tp_buf_pp #(.BW(BW), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
`ifdef TP_BUF_PASS_EN
        ,
        .tp_mode   (tp_mode)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Output k of a transposed block is element [k % N][k / N]; row-major otherwise.
    function automatic void push_block(input bit tp);
        for (int k = 0; k < NN; k++) begin
            exp_t e;
            int   r = tp ? (k % N) : (k / N);
            int   c = tp ? (k / N) : (k % N);
            e.d    = blk[r * N + c];
            e.last = (k == NN - 1);
            exp_q.push_back(e);
        end
        blk.delete();
        pend++;
    endfunction

    always @(negedge clk) begin
        bit mode;
        cyc++;
        if (rst) begin
            chk("in_ready_during_rst", 32'(in_ready), 32'(0));
            exp_q.delete();
            blk.delete();
            pend = 0;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(pend > 0));
            chk("in_ready", 32'(in_ready), 32'(pend < 2));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(1), 32'(0));
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_q[0].d));
                    chk("out_last", 32'(out_last), 32'(exp_q[0].last));
                    if (out_ready) begin
                        if (exp_q[0].last) pend--;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("out_data_idle", 32'(out_data), 32'(0));
                chk("out_last_idle", 32'(out_last), 32'(0));
            end
            if (in_valid && in_ready) begin
                blk.push_back(in_data);
`ifdef TP_BUF_PASS_EN
                mode = tp_mode;
`else
                mode = 1'b1;
`endif
                if (blk.size() == NN) push_block(mode);
            end
        end
    end

    // Sends n_in elements, then keeps the consumer running until every block is drained.
    task automatic run(input int n_in, input int pv, input int pr, input bit rnd, input int budget);
        int sent = 0;
        int n    = 0;
        bit fire;
        while ((sent < n_in || pend > 0) && n < budget) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            if (fire) sent++;
            @(posedge clk);
            #1;
            if (fire) in_data = rnd ? BW'($urandom) : in_data + 8'd1;
            in_valid  = (sent < n_in) && ($urandom_range(99) < pv);
            out_ready = ($urandom_range(99) < pr);
            n++;
        end
        in_valid = 1'b0;
        if (n >= budget) chk("run_timeout", 32'(1), 32'(0));
    endtask

    initial begin
        int fires;
        bit f;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        in_data = 8'd0;
        run(NN, 100, 100, 1'b0, 1000);

        in_data = 8'd0;
        run(3 * NN, 100, 100, 1'b0, 1000);

        in_data   = 8'd0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        fires     = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            f = in_valid && in_ready;
            if (f) fires++;
            @(posedge clk);
            #1;
            if (f) in_data = in_data + 8'd1;
        end
        chk("bp_accepted", 32'(fires), 32'(2 * NN));
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'(0));
        chk("bp_out_data", 32'(out_data), 32'(0));
        in_valid = 1'b0;
        run(0, 0, 100, 1'b0, 1000);

        run(20 * NN, 50, 50, 1'b1, 20000);

        in_data   = 8'd0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        fires     = 0;
        for (int i = 0; i < 100 && fires < 30; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) fires++;
            @(posedge clk);
            #1;
            in_data = 8'(fires);
        end
        chk("pre_rst_accepted", 32'(fires), 32'(30));
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 32'(out_valid), 32'(0));
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));
        in_data = 8'd100;
        run(NN, 100, 100, 1'b0, 500);

`ifdef TP_BUF_PASS_EN
        tp_mode = 1'b0;
        in_data = 8'd0;
        run(NN, 100, 100, 1'b0, 500);
        tp_mode = 1'b1;
        in_data = 8'd64;
        run(NN, 100, 100, 1'b0, 500);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
